// File: rtl/alu_1bit_if.sv
// Operand, select, enable and result bundle for one alu_1bit slice.
// The master drives operands/select/enable; the slave (the ALU) drives all results.
interface alu_1bit_if;
    logic       A;
    logic       B;
    logic       Cin;
    logic [1:0] S;
    logic       en;
    logic       F;
    logic       Cout;
    logic       F_q;
    logic       Cout_q;

    modport master (
        output A, B, Cin, S, en,
        input  F, Cout, F_q, Cout_q
    );

    modport slave (
        input  A, B, Cin, S, en,
        output F, Cout, F_q, Cout_q
    );
endinterface

// File: rtl/alu_1bit.sv
// Single-bit ALU slice: AND/OR/XOR/full-add, with a combinational result
// and an enable-captured registered copy for bit-serial use.
module alu_1bit (
    input  logic       clk,
    input  logic       rst,
    alu_1bit_if.slave  bus
);

    typedef enum logic [1:0] {
        OpAnd = 2'b00,
        OpOr  = 2'b01,
        OpXor = 2'b10,
        OpAdd = 2'b11
    } op_e;

    logic f_comb;
    logic cout_comb;
    logic f_d;
    logic f_q;
    logic cout_d;
    logic cout_q;

    // Carry-out is only meaningful for ADD; other ops force it low and ignore Cin.
    always_comb begin
        f_comb    = 1'b0;
        cout_comb = 1'b0;
        unique case (op_e'(bus.S))
            OpAnd: f_comb = bus.A & bus.B;
            OpOr:  f_comb = bus.A | bus.B;
            OpXor: f_comb = bus.A ^ bus.B;
            OpAdd: begin
                f_comb    = bus.A ^ bus.B ^ bus.Cin;
                cout_comb = (bus.A & bus.B) | (bus.A & bus.Cin) | (bus.B & bus.Cin);
            end
            default: begin
                f_comb    = 1'b0;
                cout_comb = 1'b0;
            end
        endcase
    end

    always_comb begin
        f_d    = f_q;
        cout_d = cout_q;
        if (bus.en) begin
            f_d    = f_comb;
            cout_d = cout_comb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q    <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            f_q    <= f_d;
            cout_q <= cout_d;
        end
    end

    assign bus.F      = f_comb;
    assign bus.Cout   = cout_comb;
    assign bus.F_q    = f_q;
    assign bus.Cout_q = cout_q;

endmodule

// File: tb/tb_alu_1bit.sv
// Directed self-checking bench for alu_1bit: combinational table, async reset,
// enable hold, bit-serial 3+1 and a full sweep of select/operand combinations.
module tb_alu_1bit;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    alu_1bit_if bus ();

    alu_1bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoding table: returns {F, Cout}.
    function automatic logic [1:0] model(input logic [1:0] s, input logic a, input logic b,
                                         input logic c);
        case (s)
            2'b00:   return {a & b, 1'b0};
            2'b01:   return {a | b, 1'b0};
            2'b10:   return {a ^ b, 1'b0};
            default: return {(a + b + c) % 2 == 1, (a + b + c) >= 2};
        endcase
    endfunction

    logic [2:0] add_vec [5] = '{3'b000, 3'b010, 3'b101, 3'b110, 3'b111};
    logic [1:0] add_exp [5] = '{2'b00, 2'b10, 2'b01, 2'b01, 2'b11};
    logic       ser_a   [3] = '{1'b1, 1'b1, 1'b0};
    logic       ser_b   [3] = '{1'b1, 1'b0, 1'b0};
    logic       ser_f   [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        rst     = 1'b1;
        bus.A   = 1'b0;
        bus.B   = 1'b0;
        bus.Cin = 1'b0;
        bus.S   = 2'b00;
        bus.en  = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("reset_regs", {bus.F_q, bus.Cout_q}, 2'b00);
        @(negedge clk);
        rst    = 1'b0;
        bus.en = 1'b0;

        // Combinational ADD vectors, 10 ns apart
        bus.S = 2'b11;
        for (int i = 0; i < 5; i++) begin
            {bus.A, bus.B, bus.Cin} = add_vec[i];
            #1 check($sformatf("add_%03b", add_vec[i]), {bus.F, bus.Cout}, add_exp[i]);
            #9;
        end

        // Logic ops with Cin=1 must ignore it
        {bus.A, bus.B, bus.Cin} = 3'b111;
        bus.S = 2'b00;
        #1 check("and_111", {bus.F, bus.Cout}, 2'b10);
        bus.S = 2'b01;
        #1 check("or_111", {bus.F, bus.Cout}, 2'b10);
        bus.S = 2'b10;
        #1 check("xor_111", {bus.F, bus.Cout}, 2'b00);
        bus.B = 1'b0;
        #1 check("xor_10", {bus.F, bus.Cout}, 2'b10);

        // Capture 1/1, then reset asynchronously mid-cycle
        @(negedge clk);
        bus.S = 2'b11;
        {bus.A, bus.B, bus.Cin} = 3'b111;
        bus.en = 1'b1;
        @(posedge clk);
        #1 check("capture_11", {bus.F_q, bus.Cout_q}, 2'b11);
        #2 rst = 1'b1;
        #1 check("async_rst_regs", {bus.F_q, bus.Cout_q}, 2'b00);
        check("async_rst_comb", {bus.F, bus.Cout}, 2'b11);
        @(posedge clk);
        #1 check("rst_held", {bus.F_q, bus.Cout_q}, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        // Enable capture then hold
        {bus.A, bus.B, bus.Cin} = 3'b101;
        bus.en = 1'b1;
        @(posedge clk);
        #1 check("en_capture", {bus.F_q, bus.Cout_q}, 2'b01);
        @(negedge clk);
        bus.en = 1'b0;
        {bus.A, bus.B, bus.Cin} = 3'b010;
        #1 check("hold_comb", {bus.F, bus.Cout}, 2'b10);
        repeat (2) @(posedge clk);
        #1 check("hold_regs", {bus.F_q, bus.Cout_q}, 2'b01);

        // Bit-serial 3 + 1, LSB first, carry fed back from Cout_q
        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        bus.S  = 2'b11;
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            bus.A   = ser_a[i];
            bus.B   = ser_b[i];
            bus.Cin = bus.Cout_q;
            @(posedge clk);
            #1 check($sformatf("serial_bit%0d", i), {1'b0, bus.F_q}, {1'b0, ser_f[i]});
        end
        check("serial_cout", {1'b0, bus.Cout_q}, 2'b00);

        // Full sweep of S, A, B, Cin
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            logic [1:0] e;
            v = 5'(i);
            @(negedge clk);
            {bus.S, bus.A, bus.B, bus.Cin} = v;
            bus.en = 1'b1;
            e = model(v[4:3], v[2], v[1], v[0]);
            #1 check($sformatf("sweep_comb_%05b", v), {bus.F, bus.Cout}, e);
            @(posedge clk);
            #1 check($sformatf("sweep_reg_%05b", v), {bus.F_q, bus.Cout_q}, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
